// File: rtl/head_flit_route_unit.sv
// Per-VC head flit assembly, route decode and single-request arbitration for one router input port.
// Define HFB_RR_ARBITER_EN for round-robin VC arbitration; otherwise the lowest-index VC in REQ wins.

// Ring route decode. The destination node sits in the low bits of the first phit. The request
// code is 0 for local eject, 1 for the clockwise direction when the destination is at most N/2
// hops away clockwise, and 2 for counter-clockwise.
module HeadFlitDecoder #(
    parameter int unsigned N             = 4,
    parameter int unsigned INDEX         = 1,
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned PhitPerFlit   = 2,
    parameter int unsigned REQUEST_WIDTH = 2
) (
    input  logic [DATA_WIDTH*PhitPerFlit-1:0] HeadFlit,
    output logic [REQUEST_WIDTH-1:0]          RequestMessage
);
    localparam int unsigned NW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned FW = DATA_WIDTH * PhitPerFlit;

    logic [NW-1:0] dest;
    logic          unusedBits;

    assign dest       = HeadFlit[NW-1:0];
    assign unusedBits = ^HeadFlit[FW-1:NW];

    always_comb begin
        int unsigned hops;
        hops           = (32'(dest) + N - INDEX) % N;
        RequestMessage = '0;
        if (hops == 0) begin
            RequestMessage = REQUEST_WIDTH'(0);
        end else if (hops <= N / 2) begin
            RequestMessage = REQUEST_WIDTH'(1);
        end else begin
            RequestMessage = REQUEST_WIDTH'(2);
        end
    end
endmodule

module head_flit_route_unit #(
    parameter int unsigned N             = 4,
    parameter int unsigned INDEX         = 1,
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned PhitPerFlit   = 2,
    parameter int unsigned REQUEST_WIDTH = 2,
    parameter int unsigned VC            = 2,
    localparam int unsigned VCW          = (VC > 1) ? $clog2(VC) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     phit_valid,
    input  logic [VCW-1:0]           phit_vc,
    input  logic [DATA_WIDTH-1:0]    head_phit,
    output logic [VC-1:0]            head_ready,
    output logic                     route_req_valid,
    output logic [REQUEST_WIDTH-1:0] route_req,
    output logic [VCW-1:0]           route_req_vc,
    input  logic                     route_grant,
    output logic [VC-1:0]            route_granted,
    output logic                     overflow_err
);
    localparam int unsigned CW = $clog2(PhitPerFlit) + 1;
    localparam int unsigned FW = DATA_WIDTH * PhitPerFlit;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ASSEMBLE = 2'd1,
        REQ      = 2'd2,
        LOCKED   = 2'd3
    } vcState_t;

    vcState_t                 stateQ [VC];
    vcState_t                 stateD [VC];
    logic [CW-1:0]            cntQ   [VC];
    logic [CW-1:0]            cntD   [VC];
    logic [FW-1:0]            bufQ   [VC];
    logic [REQUEST_WIDTH-1:0] decReq [VC];

    logic [VC-1:0]            readyVc;
    logic [VC-1:0]            reqVc;
    logic [VC-1:0]            capVc;
    logic                     anyReq;
    logic [VCW-1:0]           selVc;
    logic                     grantFire;

    logic                     busyQ;
    logic [VCW-1:0]           curVcQ;
    logic [REQUEST_WIDTH-1:0] routeReqQ;
    logic                     overflowQ;

    for (genvar v = 0; v < VC; v++) begin : gDec
        HeadFlitDecoder #(
            .N             (N),
            .INDEX         (INDEX),
            .DATA_WIDTH    (DATA_WIDTH),
            .PhitPerFlit   (PhitPerFlit),
            .REQUEST_WIDTH (REQUEST_WIDTH)
        ) uDec (
            .HeadFlit       (bufQ[v]),
            .RequestMessage (decReq[v])
        );
    end

    // Per-VC status flags; a phit whose VC matches no channel is captured by none.
    always_comb begin
        readyVc = '0;
        reqVc   = '0;
        capVc   = '0;
        for (int v = 0; v < VC; v++) begin
            readyVc[v] = (stateQ[v] == IDLE) || (stateQ[v] == ASSEMBLE);
            reqVc[v]   = (stateQ[v] == REQ);
            capVc[v]   = phit_valid && (phit_vc == VCW'(v)) && readyVc[v];
        end
    end

    assign grantFire = route_grant & busyQ;

`ifdef HFB_RR_ARBITER_EN
    logic [VCW-1:0]  rrPtrQ;
    logic [2*VC-1:0] reqTwice;

    // Rotate the request vector so the pointer position becomes bit 0, then take the first hit.
    always_comb begin
        reqTwice = {reqVc, reqVc} >> rrPtrQ;
        anyReq   = |reqVc;
        selVc    = '0;
        for (int k = VC - 1; k >= 0; k--) begin
            if (reqTwice[k]) begin
                selVc = VCW'((32'(rrPtrQ) + 32'(k)) % VC);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rrPtrQ <= '0;
        end else if (grantFire) begin
            rrPtrQ <= VCW'((32'(curVcQ) + 1) % VC);
        end
    end
`else
    always_comb begin
        anyReq = |reqVc;
        selVc  = '0;
        for (int v = VC - 1; v >= 0; v--) begin
            if (reqVc[v]) begin
                selVc = VCW'(v);
            end
        end
    end
`endif

    // Per-VC next state and phit counter.
    always_comb begin
        for (int v = 0; v < VC; v++) begin
            stateD[v] = stateQ[v];
            cntD[v]   = cntQ[v];
            unique case (stateQ[v])
                IDLE, ASSEMBLE: begin
                    if (capVc[v]) begin
                        if (cntQ[v] == CW'(PhitPerFlit - 1)) begin
                            cntD[v]   = '0;
                            stateD[v] = REQ;
                        end else begin
                            cntD[v]   = cntQ[v] + CW'(1);
                            stateD[v] = ASSEMBLE;
                        end
                    end
                end
                REQ: begin
                    if (!busyQ && anyReq && (selVc == VCW'(v))) begin
                        stateD[v] = LOCKED;
                    end
                end
                LOCKED: begin
                    if (grantFire && (curVcQ == VCW'(v))) begin
                        stateD[v] = IDLE;
                    end
                end
                default: stateD[v] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int v = 0; v < VC; v++) begin
                stateQ[v] <= IDLE;
                cntQ[v]   <= '0;
            end
        end else begin
            for (int v = 0; v < VC; v++) begin
                stateQ[v] <= stateD[v];
                cntQ[v]   <= cntD[v];
            end
        end
    end

    // Head buffers: phit slot selected by the counter; the whole buffer clears on release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int v = 0; v < VC; v++) begin
                bufQ[v] <= '0;
            end
        end else begin
            for (int v = 0; v < VC; v++) begin
                if (grantFire && (curVcQ == VCW'(v))) begin
                    bufQ[v] <= '0;
                end else if (capVc[v]) begin
                    for (int p = 0; p < PhitPerFlit; p++) begin
                        if (cntQ[v] == CW'(p)) begin
                            bufQ[v][p*DATA_WIDTH +: DATA_WIDTH] <= head_phit;
                        end
                    end
                end
            end
        end
    end

    // Request owner: holds one decoded request until the switch grants it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busyQ     <= 1'b0;
            curVcQ    <= '0;
            routeReqQ <= '0;
        end else if (grantFire) begin
            busyQ <= 1'b0;
        end else if (!busyQ && anyReq) begin
            busyQ     <= 1'b1;
            curVcQ    <= selVc;
            routeReqQ <= decReq[selVc];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflowQ <= 1'b0;
        end else if (phit_valid && !(|capVc)) begin
            overflowQ <= 1'b1;
        end
    end

    always_comb begin
        route_granted = '0;
        for (int v = 0; v < VC; v++) begin
            route_granted[v] = grantFire && (curVcQ == VCW'(v));
        end
    end

    assign head_ready      = readyVc;
    assign route_req_valid = busyQ;
    assign route_req       = routeReqQ;
    assign route_req_vc    = curVcQ;
    assign overflow_err    = overflowQ;
endmodule

// File: tb/tb_head_flit_route_unit.sv
// Bench for head_flit_route_unit: directed vector table, grant-order and async-reset sequences,
// then random traffic against a queue-based reference model.
module tb_head_flit_route_unit;
    localparam int unsigned N     = 4;
    localparam int unsigned INDEX = 1;
    localparam int unsigned DW    = 8;
    localparam int unsigned PPF   = 2;
    localparam int unsigned RW    = 2;
    localparam int unsigned VC    = 2;
    localparam int unsigned VCW   = 1;

    logic           clk = 1'b0;
    logic           rst;
    logic           phit_valid;
    logic [VCW-1:0] phit_vc;
    logic [DW-1:0]  head_phit;
    logic [VC-1:0]  head_ready;
    logic           route_req_valid;
    logic [RW-1:0]  route_req;
    logic [VCW-1:0] route_req_vc;
    logic           route_grant;
    logic [VC-1:0]  route_granted;
    logic           overflow_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    head_flit_route_unit #(
        .N(N), .INDEX(INDEX), .DATA_WIDTH(DW), .PhitPerFlit(PPF), .REQUEST_WIDTH(RW), .VC(VC)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .phit_valid      (phit_valid),
        .phit_vc         (phit_vc),
        .head_phit       (head_phit),
        .head_ready      (head_ready),
        .route_req_valid (route_req_valid),
        .route_req       (route_req),
        .route_req_vc    (route_req_vc),
        .route_grant     (route_grant),
        .route_granted   (route_granted),
        .overflow_err    (overflow_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a phit queue per VC (full queue = complete head) and one request owner.
    byte unsigned  mQ [VC][$];
    bit            mBusy;
    int            mOwner;
    logic [RW-1:0] mReq;
    bit            mOvf;
    int            mPtr;

    function automatic logic [RW-1:0] routeOf(int unsigned dest);
        int unsigned hops;
        hops = (dest + N - INDEX) % N;
        if (hops == 0) return RW'(0);
        if (hops <= N / 2) return RW'(1);
        return RW'(2);
    endfunction

    function automatic void mReset();
        for (int v = 0; v < VC; v++) mQ[v].delete();
        mBusy  = 1'b0;
        mOwner = 0;
        mReq   = '0;
        mOvf   = 1'b0;
        mPtr   = 0;
    endfunction

    function automatic logic [VC-1:0] mReady();
        logic [VC-1:0] r;
        r = '0;
        for (int v = 0; v < VC; v++) r[v] = (mQ[v].size() < PPF);
        return r;
    endfunction

    function automatic void mStep(bit pv, int vc, byte unsigned d, bit g);
        int sel;
        int v;
        sel = -1;
        if (!mBusy) begin
            for (int k = 0; k < VC; k++) begin
`ifdef HFB_RR_ARBITER_EN
                v = (mPtr + k) % VC;
`else
                v = k;
`endif
                if (sel < 0 && mQ[v].size() == PPF) sel = v;
            end
        end
        if (pv) begin
            if (vc < VC && mQ[vc].size() < PPF) mQ[vc].push_back(d);
            else mOvf = 1'b1;
        end
        if (g && mBusy) begin
            mQ[mOwner].delete();
            mBusy = 1'b0;
            mPtr  = (mOwner + 1) % VC;
        end else if (sel >= 0) begin
            mBusy  = 1'b1;
            mOwner = sel;
            mReq   = routeOf(int'(mQ[sel][0]) % N);
        end
    endfunction

    // One clock cycle with model-checked outputs; called at (active edge + 1).
    task automatic cyc(input bit pv, input int vc, input logic [7:0] d, input bit g);
        phit_valid  = pv;
        phit_vc     = VCW'(vc);
        head_phit   = d;
        route_grant = g;
        #1;
        chk("granted", 32'(route_granted), (g && mBusy) ? (32'(1) << mOwner) : 32'(0));
        @(posedge clk);
        mStep(pv, vc, d, g);
        #1;
        chk("valid", 32'(route_req_valid), 32'(mBusy));
        if (mBusy) begin
            chk("req_vc", 32'(route_req_vc), 32'(mOwner));
            chk("req", 32'(route_req), 32'(mReq));
        end
        chk("ready", 32'(head_ready), 32'(mReady()));
        chk("overflow", 32'(overflow_err), 32'(mOvf));
        phit_valid  = 1'b0;
        route_grant = 1'b0;
    endtask

    typedef struct {
        bit         pv;
        int         vc;
        logic [7:0] d;
        bit         g;
        logic [1:0] eGnt;
        bit         eVal;
        int         eVc;
        logic [1:0] eReq;
        logic [1:0] eRdy;
        bit         eOvf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit pv, int vc, logic [7:0] d, bit g, logic [1:0] eGnt,
                                bit eVal, int eVc, logic [1:0] eReq, logic [1:0] eRdy, bit eOvf);
        vec_t r;
        r.pv = pv; r.vc = vc; r.d = d; r.g = g; r.eGnt = eGnt;
        r.eVal = eVal; r.eVc = eVc; r.eReq = eReq; r.eRdy = eRdy; r.eOvf = eOvf;
        return r;
    endfunction

    int order [4] = '{1, 0, 1, 0};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; phit_valid = 1'b0; phit_vc = '0; head_phit = '0; route_grant = 1'b0;

        // Single flit on VC0, held request, interleaved assembly, overflow, idle grant.
        tbl.push_back(mk(1, 0, 8'h12, 0, 2'b00, 0, 0, 2'd0, 2'b11, 0));
        tbl.push_back(mk(1, 0, 8'h34, 0, 2'b00, 0, 0, 2'd0, 2'b10, 0));
        for (int i = 0; i < 11; i++) tbl.push_back(mk(0, 0, 8'h00, 0, 2'b00, 1, 0, 2'd1, 2'b10, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 2'b01, 0, 0, 2'd0, 2'b11, 0));
        tbl.push_back(mk(1, 0, 8'h11, 0, 2'b00, 0, 0, 2'd0, 2'b11, 0));
        tbl.push_back(mk(1, 1, 8'h22, 0, 2'b00, 0, 0, 2'd0, 2'b11, 0));
        tbl.push_back(mk(1, 0, 8'h33, 0, 2'b00, 0, 0, 2'd0, 2'b10, 0));
        tbl.push_back(mk(1, 1, 8'h44, 0, 2'b00, 1, 0, 2'd0, 2'b00, 0));
        tbl.push_back(mk(1, 0, 8'h55, 0, 2'b00, 1, 0, 2'd0, 2'b00, 1));
        tbl.push_back(mk(0, 0, 8'h00, 1, 2'b01, 0, 0, 2'd0, 2'b01, 1));
        tbl.push_back(mk(0, 0, 8'h00, 0, 2'b00, 1, 1, 2'd1, 2'b01, 1));
        tbl.push_back(mk(0, 0, 8'h00, 1, 2'b10, 0, 0, 2'd0, 2'b11, 1));
        tbl.push_back(mk(0, 0, 8'h00, 1, 2'b00, 0, 0, 2'd0, 2'b11, 1));

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(route_req_valid), 32'd0);
        chk("rst_ready", 32'(head_ready), 32'h3);
        chk("rst_overflow", 32'(overflow_err), 32'd0);
        chk("rst_granted", 32'(route_granted), 32'd0);
        rst = 1'b1;

        foreach (tbl[i]) begin
            phit_valid  = tbl[i].pv;
            phit_vc     = VCW'(tbl[i].vc);
            head_phit   = tbl[i].d;
            route_grant = tbl[i].g;
            #1;
            chk($sformatf("vec%0d_granted", i), 32'(route_granted), 32'(tbl[i].eGnt));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_valid", i), 32'(route_req_valid), 32'(tbl[i].eVal));
            if (tbl[i].eVal) begin
                chk($sformatf("vec%0d_vc", i), 32'(route_req_vc), 32'(tbl[i].eVc));
                chk($sformatf("vec%0d_req", i), 32'(route_req), 32'(tbl[i].eReq));
            end
            chk($sformatf("vec%0d_ready", i), 32'(head_ready), 32'(tbl[i].eRdy));
            chk($sformatf("vec%0d_overflow", i), 32'(overflow_err), 32'(tbl[i].eOvf));
            phit_valid  = 1'b0;
            route_grant = 1'b0;
        end

        // Synchronous-looking reset window (away from edges) before model-checked phases.
        rst = 1'b0;
        mReset();
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Grant order: VC1 owns, VC0 waits, the freed VC is refilled while the other is owned.
        cyc(1, 1, 8'($urandom), 0);
        cyc(1, 1, 8'($urandom), 0);
        cyc(1, 0, 8'($urandom), 0);
        cyc(1, 0, 8'($urandom), 0);
        for (int i = 0; i < 4; i++) begin
            for (int w = 0; w < 8 && !route_req_valid; w++) cyc(0, 0, 8'h00, 0);
            chk("order_valid", 32'(route_req_valid), 32'd1);
            chk($sformatf("order%0d_vc", i), 32'(route_req_vc), 32'(order[i]));
            if (i < 3 && mQ[1 - order[i]].size() == 0) begin
                cyc(1, 1 - order[i], 8'($urandom), 0);
                cyc(1, 1 - order[i], 8'($urandom), 0);
            end
            cyc(0, 0, 8'h00, 1);
        end

        // Async reset mid-cycle with a request pending and VC1 half-assembled.
        cyc(1, 0, 8'h5A, 0);
        cyc(1, 0, 8'hC3, 0);
        cyc(1, 1, 8'h77, 0);
        for (int w = 0; w < 8 && !route_req_valid; w++) cyc(0, 0, 8'h00, 0);
        chk("ar_pre_valid", 32'(route_req_valid), 32'd1);
        route_grant = 1'b1;
        #2;
        chk("ar_pre_granted", 32'(route_granted), 32'h1);
        rst = 1'b0;
        #1;
        chk("ar_valid", 32'(route_req_valid), 32'd0);
        chk("ar_ready", 32'(head_ready), 32'h3);
        chk("ar_granted", 32'(route_granted), 32'd0);
        chk("ar_overflow", 32'(overflow_err), 32'd0);
        route_grant = 1'b0;
        mReset();
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        cyc(1, 1, 8'h21, 0);
        cyc(1, 1, 8'h9C, 0);
        cyc(0, 0, 8'h00, 0);
        chk("ar_fresh_valid", 32'(route_req_valid), 32'd1);
        chk("ar_fresh_vc", 32'(route_req_vc), 32'd1);
        chk("ar_fresh_req", 32'(route_req), 32'd0);
        cyc(0, 0, 8'h00, 1);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            cyc($urandom_range(0, 9) < 6, int'($urandom_range(0, VC - 1)),
                8'($urandom), $urandom_range(0, 3) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
